// File: rtl/gray_ptr_receiver.sv
// Receives a gray-coded pointer that may change asynchronously to clk, synchronizes it,
// decodes it to binary and classifies every change as a legal +/-1 step or an illegal jump.
module gray_ptr_receiver #(
  parameter int SIZE        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] gray_in,
  input  logic            err_clr,
  output logic [SIZE-1:0] bin,
  output logic            bin_valid,
  output logic            dir,
  output logic            step_err,
  output logic            err_sticky
);

  function automatic logic [SIZE-1:0] gray2bin(input logic [SIZE-1:0] g);
    logic [SIZE-1:0] b;
    b[SIZE-1] = g[SIZE-1];
    for (int i = SIZE - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [SIZE-1:0] s [SYNC_STAGES];
  logic [SIZE-1:0] g_sync;
  logic [SIZE-1:0] g_prev;
  logic [SIZE-1:0] b_prev;
  logic [SIZE-1:0] b_new;
  logic [SIZE-1:0] delta;
  logic            is_event;
  logic            is_up;
  logic            is_dn;

  // Decode and classify the synchronized value against the last accepted one
  assign g_sync   = s[SYNC_STAGES-1];
  assign b_new    = gray2bin(g_sync);
  assign delta    = b_new - b_prev;
  assign is_event = (g_sync != g_prev);
  assign is_up    = (delta == SIZE'(1));
  assign is_dn    = (delta == {SIZE{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        s[i] <= '0;
      end
      g_prev     <= '0;
      b_prev     <= '0;
      bin        <= '0;
      bin_valid  <= 1'b0;
      dir        <= 1'b0;
      step_err   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      // Synchronizer chain
      s[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        s[i] <= s[i-1];
      end

      // Event stage: pulses default low, a new error overrides err_clr
      bin_valid <= 1'b0;
      step_err  <= 1'b0;
      if (err_clr) begin
        err_sticky <= 1'b0;
      end
      if (is_event) begin
        g_prev    <= g_sync;
        b_prev    <= b_new;
        bin       <= b_new;
        bin_valid <= 1'b1;
        if (is_up) begin
          dir <= 1'b1;
        end else if (is_dn) begin
          dir <= 1'b0;
        end else begin
          step_err   <= 1'b1;
          err_sticky <= 1'b1;
        end
      end
    end
  end

endmodule
